// File: rtl/sdram_tester_pkg.sv
// Shared types, widths and the test-pattern generator step for the SDRAM memory tester.
package sdram_tester_pkg;

  localparam int          DEF_ADDR_WIDTH = 23;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_PASS,
    ST_FAIL
  } state_e;

  // Right-shift Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_soc_test_master_if.sv
// SoC-side request bus between the memory tester (master) and the SDRAM controller (slave).
interface sdram_soc_test_master_if import sdram_tester_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                    soc_side_busy_port;
  logic                    soc_side_ready_port;
  logic [DATA_WIDTH-1:0]   soc_side_rd_data_port;
  logic [ADDR_WIDTH-1:0]   soc_side_addr_port;
  logic [DATA_WIDTH-1:0]   soc_side_wr_data_port;
  logic [DATA_WIDTH/8-1:0] soc_side_wr_mask_port;
  logic                    soc_side_wr_en_port;
  logic                    soc_side_rd_en_port;

  modport master (
    input  soc_side_busy_port, soc_side_ready_port, soc_side_rd_data_port,
    output soc_side_addr_port, soc_side_wr_data_port, soc_side_wr_mask_port,
    output soc_side_wr_en_port, soc_side_rd_en_port
  );

  modport slave (
    output soc_side_busy_port, soc_side_ready_port, soc_side_rd_data_port,
    input  soc_side_addr_port, soc_side_wr_data_port, soc_side_wr_mask_port,
    input  soc_side_wr_en_port, soc_side_rd_en_port
  );

endinterface

// File: rtl/sdram_tester_lfsr.sv
// Pattern generator: reloads the seed on load, otherwise advances one step on step.
// A zero seed would lock the LFSR at zero, so it is replaced by 1.
module sdram_tester_lfsr import sdram_tester_pkg::*; #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED_EFF;
    end else if (step) begin
      value_d = lfsr_step(value_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= SEED_EFF;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sdram_soc_test_master.sv
// Built-in SDRAM tester: writes WORD_COUNT LFSR words from START_ADDR, reads them back and
// compares, reporting pass/fail, a saturating error count, the first failing word and timeouts.
module sdram_soc_test_master import sdram_tester_pkg::*; #(
  parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
  parameter int                    WORD_COUNT     = 1024,
  parameter logic [31:0]           SEED           = 32'h0000_0001,
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n_port,
  input  logic                  start_port,
  sdram_soc_test_master_if.master soc,
  output logic                  running_port,
  output logic                  done_port,
  output logic                  pass_port,
  output logic                  timeout_port,
  output logic [15:0]           error_count_port,
  output logic [ADDR_WIDTH-1:0] fail_addr_port,
  output logic [DATA_WIDTH-1:0] fail_data_port
);

  localparam int                    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_COUNT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  busy_seen_q, busy_seen_d;
  logic                  ready_seen_q, ready_seen_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic                  timeout_q, timeout_d;

  logic                  lfsr_load, lfsr_step_en;
  logic [31:0]           lfsr_value;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  waiting;

  sdram_tester_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n_port),
    .load    (lfsr_load),
    .step    (lfsr_step_en),
    .value   (lfsr_value)
  );

  assign cur_addr = START_ADDR + idx_q;
  assign exp_data = DATA_WIDTH'(lfsr_value);
  assign waiting  = (state_q == ST_WAIT_INIT) || (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_seen_d  = busy_seen_q;
    ready_seen_d = ready_seen_q;
    err_cnt_d    = err_cnt_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    timeout_d    = timeout_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start_port) begin
          state_d     = ST_WAIT_INIT;
          idx_d       = '0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          timeout_d   = 1'b0;
          lfsr_load   = 1'b1;
        end
      end
      ST_WAIT_INIT: begin
        if (!soc.soc_side_busy_port) state_d = ST_WR_ISSUE;
      end
      ST_WR_ISSUE: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        // The write is only complete once the controller has shown busy and released it.
        if (soc.soc_side_busy_port) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            lfsr_load = 1'b1;
            state_d   = ST_RD_ISSUE;
          end else begin
            idx_d        = idx_q + ADDR_WIDTH'(1);
            lfsr_step_en = 1'b1;
            state_d      = ST_WR_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (soc.soc_side_ready_port && !ready_seen_q) begin
          ready_seen_d = 1'b1;
          if (soc.soc_side_rd_data_port != exp_data) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) begin
              fail_addr_d = cur_addr;
              fail_data_d = soc.soc_side_rd_data_port;
            end
          end
        end
        if (ready_seen_d && !soc.soc_side_busy_port) begin
          if (idx_q == LAST_IDX) begin
            state_d = (err_cnt_d == 16'd0) ? ST_PASS : ST_FAIL;
          end else begin
            idx_d        = idx_q + ADDR_WIDTH'(1);
            lfsr_step_en = 1'b1;
            state_d      = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (waiting && (tmo_q == TMO_LAST) && (state_d == state_q)) begin
      state_d   = ST_FAIL;
      timeout_d = 1'b1;
    end

    if (state_d != state_q) begin
      busy_seen_d  = 1'b0;
      ready_seen_d = 1'b0;
      tmo_d        = '0;
    end else if (waiting) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_port) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      tmo_q        <= '0;
      busy_seen_q  <= 1'b0;
      ready_seen_q <= 1'b0;
      err_cnt_q    <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      busy_seen_q  <= busy_seen_d;
      ready_seen_q <= ready_seen_d;
      err_cnt_q    <= err_cnt_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      timeout_q    <= timeout_d;
    end
  end

  // IDLE is only reachable through reset, so gating on it keeps every output at zero there.
  assign soc.soc_side_addr_port    = (state_q == ST_IDLE) ? '0 : cur_addr;
  assign soc.soc_side_wr_data_port = ((state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT)) ? exp_data : '0;
  assign soc.soc_side_wr_mask_port = '0;
  assign soc.soc_side_wr_en_port   = (state_q == ST_WR_ISSUE);
  assign soc.soc_side_rd_en_port   = (state_q == ST_RD_ISSUE);

  assign running_port     = waiting || (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
  assign done_port        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass_port        = (state_q == ST_PASS);
  assign timeout_port     = timeout_q;
  assign error_count_port = err_cnt_q;
  assign fail_addr_port   = fail_addr_q;
  assign fail_data_port   = fail_data_q;

endmodule

// File: tb/tb_sdram_soc_test_master.sv
// Two tester instances, each in front of a small controller model: instance 0 starts at address 0,
// instance 1 starts near the top of the address space and has a short timeout.
module tb_sdram_soc_test_master;
  import sdram_tester_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n   = 2'b00;
  logic [1:0]  start   = 2'b00;
  logic [1:0]  no_ready = 2'b00;
  logic [1:0]  flip_en = 2'b00;
  logic [22:0] flip_addr = 23'd0;
  int          init_hold [2];

  logic [1:0]  wr_en_mon, rd_en_mon, busy_mon, running_mon, done_mon, pass_mon, tmo_mon;
  logic [22:0] addr_mon  [2];
  logic [31:0] wdat_mon  [2];
  logic [3:0]  mask_mon  [2];
  logic [15:0] errc_mon  [2];
  logic [22:0] faddr_mon [2];
  logic [31:0] fdata_mon [2];

  int checks = 0;
  int failures = 0;
  int mon_sel = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  logic [22:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic [31:0] pattern [4];
  logic [22:0] hi_addrs [4];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam logic [22:0] SA = (g == 0) ? 23'd0 : 23'h7F_FFFE;
      localparam int          TO = (g == 0) ? 4096 : 64;

      sdram_soc_test_master_if #(.ADDR_WIDTH(23), .DATA_WIDTH(32)) bus ();

      sdram_soc_test_master #(
        .ADDR_WIDTH(23), .DATA_WIDTH(32), .START_ADDR(SA), .WORD_COUNT(4),
        .SEED(32'h0000_0001), .TIMEOUT_CYCLES(TO)
      ) dut (
        .clk              (clk),
        .reset_n_port     (rst_n[g]),
        .start_port       (start[g]),
        .soc              (bus),
        .running_port     (running_mon[g]),
        .done_port        (done_mon[g]),
        .pass_port        (pass_mon[g]),
        .timeout_port     (tmo_mon[g]),
        .error_count_port (errc_mon[g]),
        .fail_addr_port   (faddr_mon[g]),
        .fail_data_port   (fdata_mon[g])
      );

      // Controller model: busy 3 cycles per access, read data 2 cycles after rd_en.
      int          busy_cnt, init_cnt, rd_dly;
      logic [22:0] rd_addr;
      logic        rdy_q;
      logic [31:0] rdat_q;
      logic [31:0] mem [int];

      always @(posedge clk) begin
        if (!rst_n[g]) begin
          busy_cnt <= 0;
          init_cnt <= init_hold[g];
          rd_dly   <= 0;
          rdy_q    <= 1'b0;
          rdat_q   <= 32'h0;
        end else begin
          rdy_q <= 1'b0;
          if (init_cnt > 0) init_cnt <= init_cnt - 1;
          if (bus.soc_side_wr_en_port) begin
            mem[int'(bus.soc_side_addr_port)] = bus.soc_side_wr_data_port;
            busy_cnt <= 3;
          end else if (bus.soc_side_rd_en_port) begin
            busy_cnt <= 3;
            rd_dly   <= 2;
            rd_addr  <= bus.soc_side_addr_port;
          end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
          end
          if (rd_dly == 1) begin
            rd_dly <= 0;
            if (!no_ready[g]) begin
              rdy_q  <= 1'b1;
              rdat_q <= (mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 32'h0) ^
                        ((flip_en[g] && (rd_addr == flip_addr)) ? 32'h1 : 32'h0);
            end
          end else if (rd_dly > 1) begin
            rd_dly <= rd_dly - 1;
          end
        end
      end

      assign bus.soc_side_busy_port    = (busy_cnt != 0) || (init_cnt != 0);
      assign bus.soc_side_ready_port   = rdy_q;
      assign bus.soc_side_rd_data_port = rdat_q;
      assign wr_en_mon[g] = bus.soc_side_wr_en_port;
      assign rd_en_mon[g] = bus.soc_side_rd_en_port;
      assign busy_mon[g]  = bus.soc_side_busy_port;
      assign addr_mon[g]  = bus.soc_side_addr_port;
      assign wdat_mon[g]  = bus.soc_side_wr_data_port;
      assign mask_mon[g]  = bus.soc_side_wr_mask_port;
    end
  endgenerate

  always @(negedge clk) begin
    if (wr_en_mon[mon_sel]) begin
      wr_addr_log.push_back(addr_mon[mon_sel]);
      wr_data_log.push_back(wdat_mon[mon_sel]);
    end
    if (rd_en_mon[mon_sel]) rd_cnt++;
    if ((wr_en_mon & rd_en_mon) != 2'b00) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_wr(input int g, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = wr_en_mon[g];
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_done(input int g, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done_mon[g];
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int g);
    check_eq({tag, "_count"}, 64'(wr_addr_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (wr_addr_log.size() > base + i) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_log[base+i]),
                 64'((g == 0) ? 23'(i) : hi_addrs[i]));
        check_eq($sformatf("%s_data%0d", tag, i), 64'(wr_data_log[base+i]), 64'(pattern[i]));
      end
    end
  endtask

  initial begin
    int wb;
    int rb;
    int waited;
    bit seen;

    pattern   = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    hi_addrs  = '{23'h7F_FFFE, 23'h7F_FFFF, 23'h00_0000, 23'h00_0001};
    init_hold = '{200, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_running", 64'(running_mon[0]), 64'd0);
    check_eq("rst_done", 64'(done_mon[0]), 64'd0);
    check_eq("rst_pass", 64'(pass_mon[0]), 64'd0);
    check_eq("rst_timeout", 64'(tmo_mon[0]), 64'd0);
    check_eq("rst_errc", 64'(errc_mon[0]), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en_mon[0]), 64'd0);
    check_eq("rst_addr_hi_inst", 64'(addr_mon[1]), 64'd0);

    // Start while the controller is still initialising; no write may appear before busy falls.
    rst_n[0] = 1'b1;
    wb = wr_addr_log.size();
    rb = rd_cnt;
    pulse_start(0);
    check_eq("t1_running", 64'(running_mon[0]), 64'd1);
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 1000) begin
      @(negedge clk);
      waited++;
      seen = wr_en_mon[0];
    end
    check_eq("t1_wr_seen", 64'(seen), 64'd1);
    check_eq("t1_wr_after_init", 64'(waited >= 190), 64'd1);
    check_eq("t1_first_addr", 64'(addr_mon[0]), 64'd0);
    check_eq("t1_first_data", 64'(wdat_mon[0]), 64'h1);
    check_eq("t1_mask", 64'(mask_mon[0]), 64'd0);
    init_hold[0] = 0;

    wait_done(0, "t2_done_reached");
    check_eq("t2_pass", 64'(pass_mon[0]), 64'd1);
    check_eq("t2_errc", 64'(errc_mon[0]), 64'd0);
    check_eq("t2_timeout", 64'(tmo_mon[0]), 64'd0);
    check_eq("t2_running", 64'(running_mon[0]), 64'd0);
    check_eq("t2_reads", 64'(rd_cnt - rb), 64'd4);
    check_writes("t2_wr", wb, 0);

    // Corrupt bit 0 of word 2 on the way back.
    flip_en[0] = 1'b1;
    flip_addr  = 23'd2;
    rb = rd_cnt;
    pulse_start(0);
    wait_done(0, "t3_done_reached");
    check_eq("t3_pass", 64'(pass_mon[0]), 64'd0);
    check_eq("t3_errc", 64'(errc_mon[0]), 64'd1);
    check_eq("t3_fail_addr", 64'(faddr_mon[0]), 64'd2);
    check_eq("t3_fail_data", 64'(fdata_mon[0]), 64'hC030_0003);
    check_eq("t3_reads", 64'(rd_cnt - rb), 64'd4);
    flip_en[0] = 1'b0;

    // Reset in the middle of the second write's wait.
    pulse_start(0);
    wait_wr(0, "t5_wr0_seen");
    wait_wr(0, "t5_wr1_seen");
    @(negedge clk);
    check_eq("t5_running_before", 64'(running_mon[0]), 64'd1);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_wr_en", 64'(wr_en_mon[0]), 64'd0);
    check_eq("t5_running", 64'(running_mon[0]), 64'd0);
    check_eq("t5_done", 64'(done_mon[0]), 64'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    pulse_start(0);
    wait_wr(0, "t5_restart_wr_seen");
    check_eq("t5_restart_addr", 64'(addr_mon[0]), 64'd0);
    check_eq("t5_restart_data", 64'(wdat_mon[0]), 64'h1);
    wait_done(0, "t5_done_reached");
    check_eq("t5_pass", 64'(pass_mon[0]), 64'd1);

    // Wrap-around addressing, with a start pulse mid-run that must be ignored.
    mon_sel = 1;
    @(negedge clk);
    rst_n[1] = 1'b1;
    wb = wr_addr_log.size();
    rb = rd_cnt;
    pulse_start(1);
    wait_wr(1, "t6_wr_seen");
    pulse_start(1);
    wait_done(1, "t6_done_reached");
    check_eq("t6_pass", 64'(pass_mon[1]), 64'd1);
    check_eq("t6_errc", 64'(errc_mon[1]), 64'd0);
    check_eq("t6_reads", 64'(rd_cnt - rb), 64'd4);
    check_writes("t6_wr", wb, 1);

    // Read data never returns: timeout 64 cycles after entering the read wait.
    no_ready[1] = 1'b1;
    pulse_start(1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = rd_en_mon[1];
    end
    check_eq("t4_rd_seen", 64'(seen), 64'd1);
    repeat (64) @(posedge clk);
    #1;
    check_eq("t4_done_early", 64'(done_mon[1]), 64'd0);
    @(posedge clk);
    #1;
    check_eq("t4_done", 64'(done_mon[1]), 64'd1);
    check_eq("t4_timeout", 64'(tmo_mon[1]), 64'd1);
    check_eq("t4_pass", 64'(pass_mon[1]), 64'd0);
    check_eq("t4_running", 64'(running_mon[1]), 64'd0);

    check_eq("no_wr_rd_overlap", 64'(both_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
